esp_spi_responder: RTL and testbench

FPGA-side responder for the ESP32 SPI link (`CS_FPGA`, `SCK`, `MOSI`, `MISO`), with the `REQ`/`DONE` attention handshake.
- The ESP32 is always SPI master; this block deserialises its bytes into the `clk_in` domain, frames them, and shifts reply bytes back.
- It sits between the top-level pins and the command/register logic that serves the TRS-80 bus.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, `CS_FPGA` active-low. All SPI pins are oversampled; no logic is clocked by `SCK`.

---
 rtl/esp_spi_pkg.sv | 13 +
 rtl/esp_spi_responder_sync_ff.sv | 22 ++
 rtl/esp_spi_responder.sv | 171 +++++++++++++++++
 tb/tb_esp_spi_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/esp_spi_pkg.sv
// Shared types and constants for the ESP32 SPI responder.
package esp_spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [7:0] BYTE_IDX_MAX = 8'd255;
    localparam logic       MISO_IDLE    = 1'b1;

endpackage

// File: rtl/esp_spi_responder_sync_ff.sv
// Flop-chain synchroniser with a configurable depth and reset value.
module sync_ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) chain <= {SYNC_STAGES{RESET_VAL}};
        else          chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/esp_spi_responder.sv
// ESP32 SPI responder (mode 0, MSB first, CS active-low), fully oversampled
// in the clk_in domain. Define ESP_REQ_EN to build the REQ/DONE handshake;
// otherwise REQ and done_pulse are tied low.
module esp_spi_responder
    import esp_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_in,
    input  logic       reset_n,
    input  logic       CS_FPGA,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic [7:0] byte_idx,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       frame_active,
    output logic       frame_end,
    output logic       frame_abort,
    input  logic       req_start,
    output logic       REQ,
    input  logic       DONE,
    output logic       done_pulse
);

    state_t     state, state_next;
    logic       cs_s, sck_s, mosi_s, primed;
    logic       cs_prev, sck_prev;
    logic       cs_fall, sck_rise, sck_fall;
    logic       start, finish, shift, wrap, adv;
    logic [2:0] cnt;
    logic [6:0] rx_sr;
    logic [6:0] tx_sr;
    logic       skip;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs   (.clk_in, .reset_n, .d(CS_FPGA), .q(cs_s));
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sck  (.clk_in, .reset_n, .d(SCK),     .q(sck_s));
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (.clk_in, .reset_n, .d(MOSI),    .q(mosi_s));
    // The CS chain resets to "deselected", so that value cannot be trusted
    // until the chain has flushed; this marker rises exactly then.
    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_settle    (.clk_in, .reset_n, .d(1'b1),    .q(primed));

    assign cs_fall  = cs_prev & ~cs_s;
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;

    // Frame state register.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) state <= WAIT_IDLE;
        else          state <= state_next;
    end

    // Next state; a CS release is deferred while an SCK rise is being taken.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            WAIT_IDLE: if (primed && cs_s) state_next = IDLE;
            IDLE: if (cs_fall) begin
                state_next = ACTIVE;
                start      = 1'b1;
            end
            ACTIVE: if (cs_s && !sck_rise) begin
                state_next = IDLE;
                finish     = 1'b1;
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    assign shift = (state == ACTIVE) && sck_rise;
    assign wrap  = shift && (cnt == 3'd7);
    assign adv   = (state == ACTIVE) && sck_fall && !finish;

    // Receive/transmit datapath and strobes.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cs_prev      <= 1'b1;
            sck_prev     <= 1'b1;
            cnt          <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            skip         <= 1'b0;
            MISO         <= MISO_IDLE;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_first     <= 1'b0;
            byte_idx     <= '0;
            tx_load      <= 1'b0;
            frame_active <= 1'b0;
            frame_end    <= 1'b0;
            frame_abort  <= 1'b0;
        end else begin
            cs_prev     <= cs_s;
            sck_prev    <= sck_s;
            rx_valid    <= wrap;
            tx_load     <= start || wrap;
            frame_end   <= finish;
            frame_abort <= finish && (cnt != 3'd0);
            if (start) begin
                cnt          <= '0;
                byte_idx     <= '0;
                skip         <= 1'b0;
                frame_active <= 1'b1;
            end
            if (shift) begin
                rx_sr <= {rx_sr[5:0], mosi_s};
                cnt   <= cnt + 3'd1;
                if (wrap) begin
                    rx_data  <= {rx_sr, mosi_s};
                    rx_first <= (byte_idx == 8'd0);
                    skip     <= 1'b1;
                end
            end
            // Index advances once the strobe has shown the current position.
            if (rx_valid && byte_idx != BYTE_IDX_MAX) byte_idx <= byte_idx + 8'd1;
            // The reload puts the new MSB out at once, so the falling edge
            // that follows it must leave MISO alone.
            if (tx_load) begin
                tx_sr <= tx_data[6:0];
                MISO  <= tx_data[7];
            end else if (adv) begin
                if (skip) begin
                    skip <= 1'b0;
                end else begin
                    tx_sr <= {tx_sr[5:0], 1'b0};
                    MISO  <= tx_sr[6];
                end
            end
            if (finish) begin
                frame_active <= 1'b0;
                MISO         <= MISO_IDLE;
            end
        end
    end

`ifdef ESP_REQ_EN
    logic done_s, done_prev;

    sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_done (.clk_in, .reset_n, .d(DONE), .q(done_s));

    // REQ set by req_start; a DONE rise while pending clears it and wins ties.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            done_prev  <= 1'b0;
            REQ        <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_prev  <= done_s;
            done_pulse <= 1'b0;
            if (REQ && done_s && !done_prev) begin
                REQ        <= 1'b0;
                done_pulse <= 1'b1;
            end else if (req_start) begin
                REQ <= 1'b1;
            end
        end
    end
`else
    logic unused_req;
    assign unused_req = req_start ^ DONE;
    assign REQ        = 1'b0;
    assign done_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_esp_spi_responder.sv
// Bench for esp_spi_responder: drives SPI frames as the ESP32 master and
// checks received bytes, reply bits and frame strobes against a byte model.
module tb_esp_spi_responder;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    logic       clk_in = 1'b0, reset_n = 1'b0;
    logic       CS_FPGA = 1'b1, SCK = 1'b0, MOSI = 1'b0;
    logic       req_start = 1'b0, DONE = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       MISO, rx_valid, rx_first, tx_load, frame_active, frame_end, frame_abort, REQ, done_pulse;
    logic [7:0] rx_data, byte_idx;

    int total = 0, bad = 0;

    always #5 clk_in = ~clk_in;

    esp_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .CS_FPGA(CS_FPGA), .SCK(SCK), .MOSI(MOSI),
        .MISO(MISO), .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first),
        .byte_idx(byte_idx), .tx_data(tx_data), .tx_load(tx_load),
        .frame_active(frame_active), .frame_end(frame_end), .frame_abort(frame_abort),
        .req_start(req_start), .REQ(REQ), .DONE(DONE), .done_pulse(done_pulse)
    );

    logic [7:0] rx_d_q[$], rx_i_q[$], mosi_q[$], reply[$], got[$];
    bit         rx_f_q[$];
    int reply_ptr = 0;
    int cyc = 0, n_load = 0, n_end = 0, n_abort = 0, n_lone = 0, n_done = 0, n_req_hi = 0;
    int last_rx_cyc = 0, last_end_cyc = 0;
    int b_load, b_end, b_abort, b_lone, n;

    // Observe strobes away from the active edge.
    always @(negedge clk_in) begin
        cyc++;
        if (rx_valid) begin
            rx_d_q.push_back(rx_data);
            rx_f_q.push_back(rx_first);
            rx_i_q.push_back(byte_idx);
            last_rx_cyc = cyc;
        end
        if (tx_load) n_load++;
        if (frame_end) begin n_end++; last_end_cyc = cyc; end
        if (frame_abort) begin n_abort++; if (!frame_end) n_lone++; end
        if (done_pulse) n_done++;
        if (REQ) n_req_hi++;
    end

    // Consumer: present the next reply byte once the current one was taken.
    always @(negedge clk_in) if (tx_load) begin
        @(posedge clk_in);
        #1;
        reply_ptr++;
        tx_data = (reply_ptr < reply.size()) ? reply[reply_ptr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int k);
        repeat (k) @(negedge clk_in);
    endtask

    // Master side of one byte (or a partial byte); samples MISO on each rise.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit cs_with_last);
        logic [7:0] m = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            MOSI = b[i];
            wait_clk(HALF);
            SCK = 1'b1;
            m = {m[6:0], MISO};
            if (cs_with_last && i == 0) CS_FPGA = 1'b1;
            wait_clk(HALF);
            SCK = 1'b0;
        end
        if (nbits == 8) got.push_back(m);
    endtask

    task automatic clear_obs();
        rx_d_q.delete(); rx_f_q.delete(); rx_i_q.delete(); got.delete();
        b_load = n_load; b_end = n_end; b_abort = n_abort; b_lone = n_lone;
    endtask

    task automatic run_frame(input string tag, input int nfull, input int npart, input bit sim_end);
        clear_obs();
        reply_ptr = 0;
        tx_data   = reply[0];
        CS_FPGA   = 1'b0;
        wait_clk(HALF);
        chk({tag, "_active"}, frame_active, 1);
        for (int k = 0; k < nfull; k++) send_bits(mosi_q[k], 8, sim_end && k == nfull - 1);
        if (npart > 0) send_bits(mosi_q[nfull], npart, 1'b0);
        if (!sim_end) begin
            wait_clk(HALF);
            CS_FPGA = 1'b1;
        end
        wait_clk(12);
    endtask

    task automatic check_frame(input string tag, input int nfull, input int npart);
        chk({tag, "_rx_count"}, rx_d_q.size(), nfull);
        chk({tag, "_miso_count"}, got.size(), nfull);
        for (int k = 0; k < nfull && k < rx_d_q.size(); k++) begin
            chk({tag, "_rx_data"}, rx_d_q[k], mosi_q[k]);
            chk({tag, "_rx_first"}, rx_f_q[k], (k == 0));
            chk({tag, "_byte_idx"}, rx_i_q[k], (k > 255) ? 255 : k);
        end
        for (int k = 0; k < nfull && k < got.size(); k++)
            chk({tag, "_miso"}, got[k], reply[k]);
        chk({tag, "_frame_end"}, n_end - b_end, 1);
        chk({tag, "_abort"}, n_abort - b_abort, (npart > 0));
        chk({tag, "_lone_abort"}, n_lone - b_lone, 0);
        chk({tag, "_tx_load"}, n_load - b_load, nfull + 1);
        chk({tag, "_inactive"}, {frame_active, MISO}, 2'b01);
    endtask

    task automatic fill(input int cnt);
        mosi_q.delete(); reply.delete();
        for (int k = 0; k < cnt; k++) begin
            mosi_q.push_back(8'($urandom));
            reply.push_back(8'($urandom));
        end
    endtask

    initial begin
        // Reset state
        wait_clk(3);
        chk("reset_state",
            {MISO, REQ, rx_valid, rx_first, tx_load, frame_active, frame_end, frame_abort, done_pulse, rx_data, byte_idx},
            {1'b1, 8'b0, 8'h00, 8'h00});
        reset_n = 1'b1;
        wait_clk(8);

        // Directed three-byte frame
        mosi_q = '{8'hA5, 8'h01, 8'hFF};
        reply  = '{8'h3C, 8'h5A, 8'h00};
        run_frame("plan3", 3, 0, 1'b0);
        check_frame("plan3", 3, 0);

        // Random frames
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 6);
            fill(n + 1);
            run_frame("rand", n, 0, 1'b0);
            check_frame("rand", n, 0);
        end

        // Deselect after 5 bits of the second byte
        fill(2);
        run_frame("abort", 1, 5, 1'b0);
        check_frame("abort", 1, 5);

        // Last SCK rise and CS rise in the same cycle
        fill(3);
        run_frame("simul", 2, 0, 1'b1);
        check_frame("simul", 2, 0);
        chk("simul_gap", last_end_cyc - last_rx_cyc, 1);

        // Reset released mid-byte with CS low
        clear_obs();
        CS_FPGA = 1'b0;
        wait_clk(HALF);
        send_bits(8'hF0, 3, 1'b0);
        reset_n = 1'b0;
        wait_clk(2);
        chk("midreset_state",
            {MISO, REQ, rx_valid, rx_first, tx_load, frame_active, frame_end, frame_abort, done_pulse, rx_data, byte_idx},
            {1'b1, 8'b0, 8'h00, 8'h00});
        reset_n = 1'b1;
        clear_obs();
        send_bits(8'h81, 8, 1'b0);
        send_bits(8'h7E, 4, 1'b0);
        wait_clk(HALF);
        chk("midreset_active", frame_active, 0);
        CS_FPGA = 1'b1;
        wait_clk(12);
        chk("midreset_rx", rx_d_q.size(), 0);
        chk("midreset_strobes", (n_load - b_load) + (n_end - b_end) + (n_abort - b_abort), 0);
        mosi_q = '{8'h42};
        reply  = '{8'h99};
        run_frame("after_reset", 1, 0, 1'b0);
        check_frame("after_reset", 1, 0);

        // Long frame: byte index saturates
        fill(301);
        run_frame("long", 300, 0, 1'b0);
        check_frame("long", 300, 0);

        // REQ / DONE handshake
        clear_obs();
        b_end = n_done;
        req_start = 1'b1;
        wait_clk(1);
        req_start = 1'b0;
`ifdef ESP_REQ_EN
        chk("req_set", REQ, 1);
`else
        chk("req_set", REQ, 0);
`endif
        wait_clk(2);
        req_start = 1'b1;
        wait_clk(1);
        req_start = 1'b0;
        wait_clk(2);
`ifdef ESP_REQ_EN
        chk("req_again", REQ, 1);
`else
        chk("req_again", REQ, 0);
`endif
        chk("req_no_done", n_done - b_end, 0);
        DONE = 1'b1;
        wait_clk(10);
        chk("done_req_clear", REQ, 0);
`ifdef ESP_REQ_EN
        chk("done_pulse_once", n_done - b_end, 1);
`else
        chk("done_pulse_none", n_done - b_end, 0);
        chk("req_never_high", n_req_hi, 0);
`endif
        DONE = 1'b0;
        wait_clk(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
